stump_sequencer: RTL and testbench

Parametrised multi-cycle control sequencer for the next-generation Stump core. It replaces the fixed fetch/execute/memory cycle with a version that handles variable-latency memory (ready handshake with timeout), debug halt and single-step, and a retired-instruction counter. It sits between the memory bus and the Stump datapath/decoder. It drives the phase strobes that the datapath already consumes (fetch, execute, memory) plus the memory read and write enables.

---
 rtl/stump_sequencer_pkg.sv | 20 ++
 rtl/stump_sequencer_wait_timer.sv | 32 +++
 rtl/stump_sequencer.sv | 149 ++++++++++++++
 tb/tb_stump_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/stump_sequencer_pkg.sv
// Shared Stump control definitions: sequencer states, load/store opcode
// decode constants and the wait-counter width helper.
package stump_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_EXECUTE = 3'd1,
    ST_MEMORY  = 3'd2,
    ST_HALT    = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  localparam logic [2:0]  OP_LDST       = 3'b011;
  localparam int unsigned LDST_LOAD_BIT = 11;

  function automatic int unsigned wait_cnt_w(input int unsigned max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/stump_sequencer_wait_timer.sv
// Consecutive not-ready cycle counter for one memory access; flags the
// not-ready cycle that exhausts the MAX_WAIT budget (MAX_WAIT=0 never times out).
module stump_wait_timer
  import stump_sequencer_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_timeout
);

  localparam int unsigned CW   = wait_cnt_w(MAX_WAIT);
  localparam int unsigned LAST = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_timeout = (MAX_WAIT != 0) && i_inc && (r_cnt == CW'(LAST));

endmodule

// File: rtl/stump_sequencer.sv
// Stump multi-cycle control sequencer: fetch/execute/memory phases with
// ready handshake, access timeout, debug halt/single-step and retire counter.
module stump_sequencer
  import stump_sequencer_pkg::*;
#(
  parameter int unsigned IR_W     = 16,
  parameter int unsigned ICOUNT_W = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IR_W-1:0]     ir,
  input  logic                mem_ready,
  input  logic                halt_req,
  input  logic                step_req,
  output logic                fetch,
  output logic                execute,
  output logic                memory,
  output logic                mem_ren,
  output logic                mem_wen,
  output logic                ir_en,
  output logic                retire,
  output logic                halted,
  output logic                bus_err,
  output logic [ICOUNT_W-1:0] instr_count
);

  state_t                r_state;
  state_t                w_next;
  logic                  r_step_pending;
  logic [ICOUNT_W-1:0]   r_instr_count;

  logic w_is_mem, w_is_load, w_is_store;
  logic w_fetch, w_execute, w_memory, w_ren, w_wen, w_ir_en, w_retire;
  logic w_halted, w_bus_err, w_step_set, w_wait_clr, w_wait_inc, w_timeout;
  state_t w_boundary;
  logic w_unused_ir;

  assign w_unused_ir = ^ir;
  assign w_is_mem    = (ir[15:13] == OP_LDST);
  assign w_is_load   = w_is_mem & ir[LDST_LOAD_BIT];
  assign w_is_store  = w_is_mem & ~ir[LDST_LOAD_BIT];
  assign w_boundary  = (r_step_pending || halt_req) ? ST_HALT : ST_FETCH;

  stump_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_wait_clr),
    .i_inc     (w_wait_inc),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_FETCH;
      r_step_pending <= 1'b0;
      r_instr_count  <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) begin
        r_step_pending <= 1'b0;
        r_instr_count  <= r_instr_count + 1'b1;
      end else if (w_step_set) begin
        r_step_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_fetch    = 1'b0;
    w_execute  = 1'b0;
    w_memory   = 1'b0;
    w_ren      = 1'b0;
    w_wen      = 1'b0;
    w_ir_en    = 1'b0;
    w_retire   = 1'b0;
    w_halted   = 1'b0;
    w_bus_err  = 1'b0;
    w_step_set = 1'b0;
    w_wait_clr = 1'b0;
    w_wait_inc = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        w_fetch = 1'b1;
        w_ren   = 1'b1;
        if (mem_ready) begin
          w_ir_en    = 1'b1;
          w_wait_clr = 1'b1;
          w_next     = ST_EXECUTE;
        end else begin
          w_wait_inc = 1'b1;
          if (w_timeout) w_next = ST_ERROR;
        end
      end
      ST_EXECUTE: begin
        w_execute = 1'b1;
        if (w_is_mem) begin
          w_next = ST_MEMORY;
        end else begin
          w_retire = 1'b1;
          w_next   = w_boundary;
        end
      end
      ST_MEMORY: begin
        w_memory = 1'b1;
        w_ren    = w_is_load;
        w_wen    = w_is_store;
        if (mem_ready) begin
          w_retire   = 1'b1;
          w_wait_clr = 1'b1;
          w_next     = w_boundary;
        end else begin
          w_wait_inc = 1'b1;
          if (w_timeout) w_next = ST_ERROR;
        end
      end
      ST_HALT: begin
        w_halted = 1'b1;
        // A step pulse wins even if halt_req drops in the same cycle.
        if (step_req) begin
          w_step_set = 1'b1;
          w_next     = ST_FETCH;
        end else if (!halt_req) begin
          w_next = ST_FETCH;
        end
      end
      ST_ERROR: begin
        w_bus_err = 1'b1;
      end
      default: begin
        w_next = ST_ERROR;
      end
    endcase
  end

  assign fetch       = w_fetch;
  assign execute     = w_execute;
  assign memory      = w_memory;
  assign mem_ren     = w_ren;
  assign mem_wen     = w_wen;
  // ir_en follows mem_ready combinationally, so hold it low during reset.
  assign ir_en       = w_ir_en & ~rst;
  assign retire      = w_retire;
  assign halted      = w_halted;
  assign bus_err     = w_bus_err;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_stump_sequencer.sv
// Directed bench for stump_sequencer: default instance for run/halt/step,
// small instance (MAX_WAIT=4, ICOUNT_W=4) for timeout, wrap and async reset.
module tb_stump_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] ir_a, ir_b;
  logic rdy_a, hreq_a, sreq_a, rdy_b, hreq_b, sreq_b;
  logic fetch_a, exec_a, mem_a, ren_a, wen_a, iren_a, ret_a, halt_a, berr_a;
  logic fetch_b, exec_b, mem_b, ren_b, wen_b, iren_b, ret_b, halt_b, berr_b;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  stump_sequencer #(.IR_W(16), .ICOUNT_W(32), .MAX_WAIT(15)) dut_a (
    .clk(clk), .rst(rst), .ir(ir_a), .mem_ready(rdy_a), .halt_req(hreq_a),
    .step_req(sreq_a), .fetch(fetch_a), .execute(exec_a), .memory(mem_a),
    .mem_ren(ren_a), .mem_wen(wen_a), .ir_en(iren_a), .retire(ret_a),
    .halted(halt_a), .bus_err(berr_a), .instr_count(cnt_a)
  );

  stump_sequencer #(.IR_W(16), .ICOUNT_W(4), .MAX_WAIT(4)) dut_b (
    .clk(clk), .rst(rst), .ir(ir_b), .mem_ready(rdy_b), .halt_req(hreq_b),
    .step_req(sreq_b), .fetch(fetch_b), .execute(exec_b), .memory(mem_b),
    .mem_ren(ren_b), .mem_wen(wen_b), .ir_en(iren_b), .retire(ret_b),
    .halted(halt_b), .bus_err(berr_b), .instr_count(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ir_a = 16'h0000; rdy_a = 1'b0; hreq_a = 1'b0; sreq_a = 1'b0;
    ir_b = 16'h0000; rdy_b = 1'b0; hreq_b = 1'b0; sreq_b = 1'b0;
    repeat (2) @(negedge clk);
    rdy_a = 1'b1;
    #1;
    chk("rst_fetch", fetch_a, 1);
    chk("rst_ren", ren_a, 1);
    chk("rst_exec", exec_a, 0);
    chk("rst_mem", mem_a, 0);
    chk("rst_wen", wen_a, 0);
    chk("rst_iren", iren_a, 0);
    chk("rst_retire", ret_a, 0);
    chk("rst_halted", halt_a, 0);
    chk("rst_buserr", berr_a, 0);
    chk("rst_count", cnt_a, 0);
    rst = 1'b0;
    #1;
    chk("first_iren", iren_a, 1);

    // ALU stream: FETCH/EXECUTE alternate, one retire per pair
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("alu_exec", exec_a, 32'(k % 2));
      chk("alu_retire", ret_a, 32'(k % 2));
      chk("alu_fetch", fetch_a, 32'(1 - k % 2));
      chk("alu_count", cnt_a, 32'(k / 2));
    end

    // Load, then store
    ir_a = 16'h6800;
    tick(); chk("ld_exec", exec_a, 1); chk("ld_exec_ret", ret_a, 0);
    tick(); chk("ld_mem", mem_a, 1); chk("ld_ren", ren_a, 1);
    chk("ld_wen", wen_a, 0); chk("ld_retire", ret_a, 1);
    tick(); chk("ld_fetch", fetch_a, 1); chk("ld_count", cnt_a, 6);
    ir_a = 16'h6000;
    tick(); chk("st_exec", exec_a, 1);
    tick(); chk("st_mem", mem_a, 1); chk("st_ren", ren_a, 0);
    chk("st_wen", wen_a, 1); chk("st_retire", ret_a, 1);
    tick(); chk("st_fetch", fetch_a, 1); chk("st_count", cnt_a, 7);

    // Fetch with three wait states
    ir_a = 16'h0000;
    rdy_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_fetch", fetch_a, 1);
      chk("wait_ren", ren_a, 1);
      chk("wait_iren", iren_a, 0);
      tick();
    end
    rdy_a = 1'b1;
    #1;
    chk("wait_done_fetch", fetch_a, 1);
    chk("wait_done_iren", iren_a, 1);
    chk("wait_no_err", berr_a, 0);
    tick(); chk("wait_exec", exec_a, 1);
    tick(); chk("wait_count", cnt_a, 8);

    // Halt requested during a load's EXECUTE
    ir_a = 16'h6800;
    tick(); chk("h_exec", exec_a, 1);
    hreq_a = 1'b1;
    tick(); chk("h_mem", mem_a, 1); chk("h_not_halted", halt_a, 0);
    tick(); chk("h_halted", halt_a, 1); chk("h_fetch0", fetch_a, 0);
    chk("h_ren0", ren_a, 0); chk("h_count", cnt_a, 9);
    tick(); chk("h_stay", halt_a, 1);

    // Three single steps; the last drops halt_req together with the step
    ir_a = 16'h0000;
    for (int s = 0; s < 3; s++) begin
      if (s == 2) hreq_a = 1'b0;
      sreq_a = 1'b1;
      tick();
      sreq_a = 1'b0;
      chk("step_fetch", fetch_a, 1);
      tick(); chk("step_retire", ret_a, 1);
      tick(); chk("step_halted", halt_a, 1); chk("step_count", cnt_a, 32'(10 + s));
    end
    tick(); chk("resume_fetch", fetch_a, 1); chk("resume_halted", halt_a, 0);
    tick(); chk("resume_exec", exec_a, 1);
    tick(); chk("resume_count", cnt_a, 13);

    // step_req while running is ignored
    sreq_a = 1'b1;
    tick();
    sreq_a = 1'b0;
    tick(); chk("ign_halted", halt_a, 0); chk("ign_fetch", fetch_a, 1);
    chk("ign_count", cnt_a, 14);

    // Small instance: counter wrap
    rst = 1'b1;
    ir_b = 16'h0000;
    rdy_b = 1'b1;
    tick();
    rst = 1'b0;
    repeat (32) tick();
    chk("wrap16", cnt_b, 0);
    chk("wrap_fetch", fetch_b, 1);
    repeat (2) tick();
    chk("wrap17", cnt_b, 1);

    // Timeout after MAX_WAIT not-ready fetch cycles
    rdy_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_pre_err", berr_b, 0);
      chk("to_pre_fetch", fetch_b, 1);
    end
    tick();
    chk("to_err", berr_b, 1);
    chk("to_fetch0", fetch_b, 0);
    chk("to_ren0", ren_b, 0);
    chk("to_exec0", exec_b, 0);
    chk("to_mem0", mem_b, 0);
    chk("to_wen0", wen_b, 0);
    chk("to_halted0", halt_b, 0);
    rdy_b = 1'b1;
    repeat (2) tick();
    chk("to_sticky", berr_b, 1);
    chk("to_sticky_fetch", fetch_b, 0);

    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    chk("arst_fetch", fetch_b, 1);
    chk("arst_ren", ren_b, 1);
    chk("arst_err", berr_b, 0);
    chk("arst_count", cnt_b, 0);
    chk("arst_iren", iren_b, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
